// File: rtl/hyperram_responder.sv
// rtl/hyperram_responder.sv - HyperRAM device model: CA decode, fixed latency, linear read/write bursts
module hyperram_responder #(
    parameter int          AddrWidth    = 8,
    parameter int          Latency      = 6,
    parameter logic [15:0] RegReadValue = 16'h8F1F
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       hyper_cs_ni,
    input  logic       hyper_ck_i,
    input  logic [7:0] hyper_dq_i,
    input  logic       hyper_rwds_i,
    output logic [7:0] hyper_dq_o,
    output logic       hyper_dq_oe_o,
    output logic       hyper_rwds_o,
    output logic       hyper_rwds_oe_o
);

    localparam int         Words   = 1 << AddrWidth;
    localparam logic [7:0] LatLast = 8'(2 * Latency - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CA   = 3'd1;
    localparam logic [2:0] S_LAT  = 3'd2;
    localparam logic [2:0] S_RD   = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;

    logic                 r_cs_m, r_cs_s, r_cs_prev;
    logic                 r_ck_m, r_ck_s, r_ck_prev;
    logic                 r_rwds_m, r_rwds_s;
    logic [7:0]           r_dq_m, r_dq_s;
    logic [2:0]           r_state;
    logic [2:0]           r_edge_cnt;
    logic [7:0]           r_lat_cnt;
    logic                 r_is_rd, r_is_reg;
    logic [AddrWidth-1:0] r_addr;
    logic [7:0]           r_wdata_hi;
    logic                 r_wbe_hi;
    logic [7:0]           r_dq_o;
    logic                 r_rwds;
    logic [15:0]          r_mem [Words];

    logic                 w_edge, w_cs_fall;
    logic [15:0]          w_rd_word;
    logic [AddrWidth-1:0] w_ca_sel, w_ca_hit;

    assign w_edge    = (r_ck_s != r_ck_prev) && !r_cs_s;
    assign w_cs_fall = r_cs_prev && !r_cs_s;
    assign w_rd_word = r_is_reg ? RegReadValue : r_mem[r_addr];

    // Word address bit j comes from CA bit j (j<3) or CA bit j+13; CA byte k arrives on CA edge k, MSB first.
    for (genvar j = 0; j < AddrWidth; j++) begin : g_ca_addr
        localparam int         CaBit  = (j < 3) ? j : j + 13;
        localparam logic [2:0] CaByte = 3'(5 - CaBit / 8);
        localparam int         CaSub  = CaBit % 8;
        assign w_ca_sel[j] = r_dq_s[CaSub];
        assign w_ca_hit[j] = (r_edge_cnt == CaByte);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cs_m     <= 1'b0;
            r_cs_s     <= 1'b0;
            r_cs_prev  <= 1'b0;
            r_ck_m     <= 1'b0;
            r_ck_s     <= 1'b0;
            r_ck_prev  <= 1'b0;
            r_rwds_m   <= 1'b0;
            r_rwds_s   <= 1'b0;
            r_dq_m     <= 8'h00;
            r_dq_s     <= 8'h00;
            r_state    <= S_IDLE;
            r_edge_cnt <= 3'd0;
            r_lat_cnt  <= 8'd0;
            r_is_rd    <= 1'b0;
            r_is_reg   <= 1'b0;
            r_addr     <= '0;
            r_wdata_hi <= 8'h00;
            r_wbe_hi   <= 1'b0;
            r_dq_o     <= 8'h00;
            r_rwds     <= 1'b0;
            for (int i = 0; i < Words; i++) begin
                r_mem[i] <= 16'h0000;
            end
        end else begin
            r_cs_m    <= hyper_cs_ni;
            r_cs_s    <= r_cs_m;
            r_cs_prev <= r_cs_s;
            r_ck_m    <= hyper_ck_i;
            r_ck_s    <= r_ck_m;
            r_ck_prev <= r_ck_s;
            r_rwds_m  <= hyper_rwds_i;
            r_rwds_s  <= r_rwds_m;
            r_dq_m    <= hyper_dq_i;
            r_dq_s    <= r_dq_m;

            // Deselect wins over any coincident CK edge; a half-written word is dropped here.
            if (r_cs_s) begin
                r_state  <= S_IDLE;
                r_rwds   <= 1'b0;
                r_wbe_hi <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_cs_fall) begin
                            r_state    <= S_CA;
                            r_edge_cnt <= 3'd0;
                            r_lat_cnt  <= 8'd0;
                            r_wbe_hi   <= 1'b0;
                            r_rwds     <= 1'b0;
                        end
                    end
                    S_CA: begin
                        if (w_edge) begin
                            if (r_edge_cnt == 3'd0) begin
                                r_is_rd  <= r_dq_s[7];
                                r_is_reg <= r_dq_s[6];
                            end
                            r_addr <= (r_addr & ~w_ca_hit) | (w_ca_sel & w_ca_hit);
                            if (r_edge_cnt == 3'd5) begin
                                r_state   <= S_LAT;
                                r_lat_cnt <= 8'd0;
                            end else begin
                                r_edge_cnt <= r_edge_cnt + 3'd1;
                            end
                        end
                    end
                    S_LAT: begin
                        if (w_edge) begin
                            if (r_lat_cnt == LatLast) begin
                                r_state <= r_is_rd ? S_RD : S_WR;
                            end else begin
                                r_lat_cnt <= r_lat_cnt + 8'd1;
                            end
                        end
                    end
                    S_RD: begin
                        if (w_edge) begin
                            r_rwds <= r_ck_s;
                            if (r_ck_s) begin
                                r_dq_o <= w_rd_word[15:8];
                            end else begin
                                r_dq_o <= w_rd_word[7:0];
                                r_addr <= r_addr + 1'b1;
                            end
                        end
                    end
                    S_WR: begin
                        if (w_edge) begin
                            if (r_ck_s) begin
                                r_wdata_hi <= r_dq_s;
                                r_wbe_hi   <= !r_rwds_s;
                            end else begin
                                if (!r_is_reg) begin
                                    if (r_wbe_hi) r_mem[r_addr][15:8] <= r_wdata_hi;
                                    if (!r_rwds_s) r_mem[r_addr][7:0] <= r_dq_s;
                                end
                                r_wbe_hi <= 1'b0;
                                r_addr   <= r_addr + 1'b1;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign hyper_dq_o      = r_dq_o;
    assign hyper_dq_oe_o   = (r_state == S_RD) && !r_cs_s;
    assign hyper_rwds_o    = (r_state == S_RD) && r_rwds && !r_cs_s;
    assign hyper_rwds_oe_o = ((r_state == S_CA) || (r_state == S_LAT) || (r_state == S_RD)) && !r_cs_s;

endmodule
